multi_cycle_ctrl: RTL
=====================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max mem_ready wait cycles per memory access before bus error.
REQ-002 SHALL have ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  instruction opcode, from the instruction register
- funct  in  6  R-type function field, from the instruction register
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory handshake: access completes this cycle
- resume  in  1  leave syscall halt
- ir_we  out  1  instruction register load
- pc_we  out  1  PC write
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs register
- iord  out  1  memory address: 0 PC, 1 ALU result
- mem_rd, mem_wr  out  1 each  memory read / write request
- reg_we  out  1  register file write
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  in HALT
- err  out  2  0 none, 1 illegal instruction, 2 bus timeout
- state  out  4  current state encoding, for debug

Function
REQ-003 SHALL be a Moore FSM; outputs decode from state, plus zero/mem_ready where stated; all outputs are 0 unless listed.
REQ-004 SHALL have states IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_REG, WB_MEM, BRANCH, JUMP and HALT.
REQ-005 IDLE SHALL go to FETCH unconditionally.
REQ-006 FETCH SHALL:
- assert mem_rd with iord=0;
- on mem_ready, pulse ir_we and pc_we with pc_src=0, then go to DECODE;
- otherwise stay in FETCH.
REQ-007 DECODE SHALL route as follows:
- supported R-type (add, addu, sub, and, or, nor, slt, sltu, sll, srl, sra) -> EXEC_R;
- jr -> JUMP;
- syscall -> HALT with err=0;
- addi, addiu, andi, ori, slti -> EXEC_I;
- lw, sw -> MEM_ADDR;
- beq, bne -> BRANCH;
- j, jal -> JUMP;
- anything else -> HALT with err=1.
REQ-008 EXEC_R SHALL go to WB_REG, and EXEC_I SHALL go to WB_REG.
REQ-009 WB_REG SHALL assert reg_we and retire, then go to FETCH.
REQ-010 MEM_ADDR SHALL go to MEM_RD for lw and to MEM_WR for sw.
REQ-011 MEM_RD SHALL assert mem_rd with iord=1 and advance to WB_MEM on mem_ready; WB_MEM SHALL assert reg_we and retire, then go to FETCH.
REQ-012 MEM_WR SHALL assert mem_wr with iord=1; on mem_ready it SHALL assert retire and go to FETCH.
REQ-013 BRANCH SHALL assert retire and go to FETCH.
- pc_we = zero for beq, ~zero for bne; pc_src=1.
REQ-014 JUMP SHALL assert pc_we and retire, then go to FETCH.
- pc_src=3 for jr, else 2.
- reg_we=1 for jal only.
REQ-015 Zero-wait latency, counted FETCH to retire inclusive, SHALL be:
- R/I-type: 4 cycles;
- lw: 5; sw: 4;
- beq, bne, j, jal, jr: 3.
- Each extra mem_ready-low cycle adds 1.
REQ-016 A wait counter SHALL work as follows:
- clears on entry to FETCH, MEM_RD or MEM_WR;
- increments each cycle mem_ready is low in those states;
- on reaching MEM_TIMEOUT with mem_ready low, the FSM goes to HALT with err=2 and issues no ir_we, pc_we or reg_we.
REQ-017 mem_ready high in the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally.
REQ-018 HALT SHALL assert halted; the opcode/funct and zero inputs SHALL be ignored.
- err=0: resume=1 goes to FETCH (counts as a new fetch, no retire).
- err!=0: the FSM SHALL stay in HALT until reset; resume is ignored.
REQ-019 mem_ready outside FETCH, MEM_RD and MEM_WR SHALL be ignored; mem_rd and mem_wr SHALL never be high together.
REQ-020 err SHALL be registered on HALT entry and held until reset or resume.

Reset
REQ-021 rst high SHALL immediately set state=IDLE, err=0 and wait counter=0; all outputs SHALL be 0.
REQ-022 rst asserted mid-access, e.g. MEM_RD waiting, SHALL abandon the access with no write-back; after deassertion the FSM SHALL restart from IDLE.

Structure
REQ-023 The state enum, opcode/funct constants, pc_src and err encodings SHALL live in the shared package def.
REQ-024 A combinational sub-module mc_decode SHALL map opcode/funct to an instruction-class enum {RTYPE, ITYPE, LOAD, STORE, BRANCH, JUMP, JR, SYSCALL, ILLEGAL}; the FSM SHALL use only that class.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- add, mem_ready tied 1 -> states IDLE, FETCH, DECODE, EXEC_R, WB_REG; retire in cycle 4 after FETCH; reg_we for 1 cycle.
- lw with mem_ready low 3 cycles in MEM_RD -> mem_rd with iord=1 held 4 cycles; retire 8 cycles after FETCH entry.
- beq: zero=1 -> pc_we=1, pc_src=1. bne: zero=1 -> pc_we=0. Both retire in 3 cycles.
- opcode 6'h3F -> HALT with err=1; resume pulse ignored; rst returns to IDLE.
- MEM_TIMEOUT=4, mem_ready held low in FETCH -> HALT with err=2 after 4 wait cycles, no ir_we; variant with mem_ready high on the 4th cycle -> normal DECODE.
- syscall, then resume after 10 cycles -> halted for 10 cycles, err=0, then FETCH; rst asserted mid-FETCH -> immediate IDLE.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, instruction classes,
// MIPS opcode/funct values, and the pc_src and err output codes.
package multi_cycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_REG   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        CLS_RTYPE, CLS_ITYPE, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JUMP, CLS_JR, CLS_SYSCALL, CLS_ILLEGAL
    } instr_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier; is_bne and is_link refine BRANCH and JUMP.
// Zero latency, no handshake.
module mc_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output instr_cls_t cls,
    output logic       is_bne,
    output logic       is_link
);

    always_comb begin
        cls     = CLS_ILLEGAL;
        is_bne  = (opcode == OP_BNE);
        is_link = (opcode == OP_JAL);
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR,
                    FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA: cls = CLS_RTYPE;
                    FN_JR:                                   cls = CLS_JR;
                    FN_SYSCALL:                              cls = CLS_SYSCALL;
                    default:                                 cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: cls = CLS_ITYPE;
            OP_LW:                                       cls = CLS_LOAD;
            OP_SW:                                       cls = CLS_STORE;
            OP_BEQ, OP_BNE:                              cls = CLS_BRANCH;
            OP_J, OP_JAL:                                cls = CLS_JUMP;
            default:                                     cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS datapath; 3-5 cycles per instruction at zero wait.
// Memory stalls on mem_ready low; MEM_TIMEOUT consecutive low cycles halt with a bus error.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       resume,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       retire,
    output logic       halted,
    output logic [1:0] err,
    output logic [3:0] state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t     st_q, st_nxt;
    logic [1:0] err_q, err_nxt;
    logic [CW-1:0] wait_cnt;
    instr_cls_t cls, cls_q;
    logic       is_bne, is_link, bne_q, link_q;
    logic       in_wait, timeout;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (cls),
        .is_bne  (is_bne),
        .is_link (is_link)
    );

    assign in_wait = (st_q == ST_FETCH) || (st_q == ST_MEM_RD) || (st_q == ST_MEM_WR);
    // The current low cycle is the MEM_TIMEOUT-th one; a high mem_ready here still completes.
    assign timeout = ~mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            err_q    <= ERR_NONE;
            wait_cnt <= '0;
            cls_q    <= CLS_ILLEGAL;
            bne_q    <= 1'b0;
            link_q   <= 1'b0;
        end else begin
            st_q     <= st_nxt;
            err_q    <= err_nxt;
            wait_cnt <= (in_wait && st_nxt == st_q) ? wait_cnt + 1'b1 : '0;
            if (st_q == ST_DECODE) begin
                cls_q  <= cls;
                bne_q  <= is_bne;
                link_q <= is_link;
            end
        end
    end

    always_comb begin
        st_nxt  = st_q;
        err_nxt = err_q;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = PC_SRC_PLUS4;
        iord    = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        reg_we  = 1'b0;
        retire  = 1'b0;
        halted  = 1'b0;
        case (st_q)
            ST_IDLE: st_nxt = ST_FETCH;
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    st_nxt = ST_DECODE;
                end else if (timeout) begin
                    st_nxt  = ST_HALT;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_RTYPE:            st_nxt = ST_EXEC_R;
                    CLS_ITYPE:            st_nxt = ST_EXEC_I;
                    CLS_LOAD, CLS_STORE:  st_nxt = ST_MEM_ADDR;
                    CLS_BRANCH:           st_nxt = ST_BRANCH;
                    CLS_JUMP, CLS_JR:     st_nxt = ST_JUMP;
                    CLS_SYSCALL: begin
                        st_nxt  = ST_HALT;
                        err_nxt = ERR_NONE;
                    end
                    default: begin
                        st_nxt  = ST_HALT;
                        err_nxt = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: st_nxt = ST_WB_REG;
            ST_MEM_ADDR: st_nxt = (cls_q == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    st_nxt = ST_WB_MEM;
                end else if (timeout) begin
                    st_nxt  = ST_HALT;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    st_nxt = ST_FETCH;
                end else if (timeout) begin
                    st_nxt  = ST_HALT;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_WB_REG, ST_WB_MEM: begin
                reg_we = 1'b1;
                retire = 1'b1;
                st_nxt = ST_FETCH;
            end
            ST_BRANCH: begin
                retire = 1'b1;
                pc_src = PC_SRC_BRANCH;
                pc_we  = bne_q ? ~zero : zero;
                st_nxt = ST_FETCH;
            end
            ST_JUMP: begin
                pc_we  = 1'b1;
                retire = 1'b1;
                pc_src = (cls_q == CLS_JR) ? PC_SRC_REG : PC_SRC_JUMP;
                reg_we = link_q;
                st_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (err_q == ERR_NONE && resume)
                    st_nxt = ST_FETCH;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    assign err   = err_q;
    assign state = st_q;

endmodule
